// File: rtl/fetch_unit.sv
// Instruction fetch: one icache request in flight, PC rewind on a missing response, {pc,inst} buffer to decode.
// Hits reach decode one cycle after icache_valid; a request is issued only when the buffer can absorb its response.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_addr,
  output logic        icache_req,
  input  logic [31:0] icache_data,
  input  logic        icache_valid,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [31:0]     pc;
  logic [31:0]     inflight_pc;
  logic            inflight;

  logic            pop;
  logic            push;
  logic            resp_ok;
  logic            resp_miss;
  logic [CW:0]     credit_used;

  always_comb begin
    inst_valid  = !rst && (count != '0);
    inst        = inst_valid ? mem[head].inst : '0;
    inst_pc     = inst_valid ? mem[head].pc   : '0;
    pop         = inst_valid & inst_ready;
    resp_ok     = inflight & icache_valid;
    resp_miss   = inflight & !icache_valid;
    push        = resp_ok & !redirect;
    // Buffered entries plus the outstanding response must leave room after this cycle's pop.
    credit_used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    icache_req  = !rst && !redirect && !resp_miss && (credit_used < (CW+1)'(FIFO_DEPTH));
    icache_addr = pc;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= '{pc: inflight_pc, inst: icache_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      pc          <= {redirect_pc[31:2], 2'b00};
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (resp_miss) begin
        // Response never came: refetch the same address when credit allows.
        pc       <= inflight_pc;
        inflight <= 1'b0;
      end else if (icache_req) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based reference model checked every cycle plus literal spot checks.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data = 32'h0;
  logic        icache_valid = 1'b0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .icache_addr  (icache_addr),
    .icache_req   (icache_req),
    .icache_data  (icache_data),
    .icache_valid (icache_valid),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc     = RESET_PC;
  bit          m_inf    = 1'b0;
  logic [31:0] m_inf_pc = 32'h0;
  logic [63:0] m_q[$];
  logic [31:0] exp_next = RESET_PC;
  logic [31:0] del_pc[$];
  bit          m_vld, m_pop, m_ok, m_miss, m_req;
  int          occ;
  logic [31:0] m_inst, m_ipc;

  // Values seen by the icache model at the last negedge
  bit          s_req  = 1'b0;
  logic [31:0] s_addr = 32'h0;
  bit          s_rst  = 1'b1;
  bit          idle_pending = 1'b1;
  bit          miss_armed   = 1'b0;
  logic [31:0] miss_addr    = 32'h0;

  always @(negedge clk) begin
    m_vld  = !rst && (m_q.size() > 0);
    m_pop  = m_vld && inst_ready;
    m_ok   = m_inf && icache_valid;
    m_miss = m_inf && !icache_valid;
    occ    = m_q.size() + (m_inf ? 1 : 0) - (m_pop ? 1 : 0);
    m_req  = !rst && !redirect && !m_miss && (occ < DEPTH);
    m_inst = 32'h0;
    m_ipc  = 32'h0;
    if (m_vld) begin
      m_inst = m_q[0][31:0];
      m_ipc  = m_q[0][63:32];
    end
    chk("req",     {31'b0, icache_req}, {31'b0, m_req});
    chk("addr",    icache_addr, m_pc);
    chk("vld",     {31'b0, inst_valid}, {31'b0, m_vld});
    chk("inst",    inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);

    // Stream property: consecutive PCs, data equals address
    if (!rst && inst_valid && inst_ready) begin
      chk("order",   inst_pc, exp_next);
      chk("payload", inst, inst_pc);
      del_pc.push_back(inst_pc);
      exp_next = inst_pc + 32'd4;
    end
    if (rst) exp_next = RESET_PC;
    else if (redirect) exp_next = redirect_pc & 32'hFFFF_FFFC;

    s_req  = icache_req;
    s_addr = icache_addr;
    s_rst  = rst;

    if (rst) begin
      m_pc  = RESET_PC;
      m_inf = 1'b0;
      m_q.delete();
    end else if (redirect) begin
      m_q.delete();
      m_inf = 1'b0;
      m_pc  = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_ok) m_q.push_back({m_inf_pc, icache_data});
      if (m_miss) begin
        m_pc  = m_inf_pc;
        m_inf = 1'b0;
      end else if (m_req) begin
        m_inf    = 1'b1;
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end else begin
        m_inf = 1'b0;
      end
    end
  end

  // icache: idle one request after reset, one armed miss, otherwise 1-cycle hit with data = addr
  always @(posedge clk) begin
    #1;
    if (s_rst) begin
      icache_valid = 1'b0;
      idle_pending = 1'b1;
    end else if (s_req && idle_pending) begin
      icache_valid = 1'b0;
      idle_pending = 1'b0;
    end else if (s_req && miss_armed && s_addr == miss_addr) begin
      icache_valid = 1'b0;
      miss_armed   = 1'b0;
    end else if (s_req) begin
      icache_valid = 1'b1;
    end else begin
      icache_valid = 1'b0;
    end
    icache_data = icache_valid ? s_addr : 32'hBAD0_0000;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] exp);
    if (idx < del_pc.size()) begin
      chk(name, del_pc[idx], exp);
    end else begin
      total++;
      bad++;
      $display("FAIL %s: only %0d delivered, wanted index %0d = %h", name, del_pc.size(), idx, exp);
    end
  endtask

  int base;

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b1;
    miss_addr   = 32'h8;
    miss_armed  = 1'b1;

    @(negedge clk);
    chk("rst_req",  {31'b0, icache_req}, 32'd0);
    chk("rst_vld",  {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ipc",  inst_pc, 32'h0);
    nxt();
    nxt();
    rst = 1'b0;

    // Streaming with the post-reset idle retry and one miss at 0x8
    @(negedge clk);
    chk("start_req",  {31'b0, icache_req}, 32'd1);
    chk("start_addr", icache_addr, 32'h0);
    nxt();
    @(negedge clk);
    chk("idle_retry_req", {31'b0, icache_req}, 32'd0);
    nxt();
    nxt();
    @(negedge clk);
    chk("first_hit_novld", {31'b0, inst_valid}, 32'd0);
    nxt();
    @(negedge clk);
    chk("first_vld", {31'b0, inst_valid}, 32'd1);
    chk("first_pc",  inst_pc, 32'h0);
    nxt();
    @(negedge clk);
    chk("miss_req", {31'b0, icache_req}, 32'd0);
    nxt();
    @(negedge clk);
    chk("reissue_req",  {31'b0, icache_req}, 32'd1);
    chk("reissue_addr", icache_addr, 32'h8);
    repeat (8) nxt();
    chk_log("stream0", 0, 32'h0);
    chk_log("stream1", 1, 32'h4);
    chk_log("stream2", 2, 32'h8);
    chk_log("stream3", 3, 32'hC);
    chk_log("stream4", 4, 32'h10);

    // Backpressure
    inst_ready = 1'b0;
    repeat (6) nxt();
    @(negedge clk);
    chk("bp_req", {31'b0, icache_req}, 32'd0);
    chk("bp_vld", {31'b0, inst_valid}, 32'd1);
    inst_ready = 1'b1;
    repeat (6) nxt();

    // Redirect with a response in flight
    base        = del_pc.size();
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    inst_ready  = 1'b0;
    @(negedge clk);
    chk("redir_req", {31'b0, icache_req}, 32'd0);
    nxt();
    redirect   = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    chk("redir_vld",  {31'b0, inst_valid}, 32'd0);
    chk("redir_addr", icache_addr, 32'h100);
    chk("redir_req2", {31'b0, icache_req}, 32'd1);
    repeat (5) nxt();
    chk_log("redir_first",  base, 32'h100);
    chk_log("redir_second", base + 1, 32'h104);

    // Wrap: redirect with a full buffer and a pop in the same cycle
    inst_ready = 1'b0;
    repeat (4) nxt();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    inst_ready  = 1'b1;
    nxt();
    base     = del_pc.size();
    redirect = 1'b0;
    @(negedge clk);
    chk("wrap_vld",  {31'b0, inst_valid}, 32'd0);
    chk("wrap_addr", icache_addr, 32'hFFFF_FFFC);
    repeat (6) nxt();
    chk_log("wrap0", base, 32'hFFFF_FFFC);
    chk_log("wrap1", base + 1, 32'h0000_0000);
    chk_log("wrap2", base + 2, 32'h0000_0004);

    // Reset mid-stream
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_req",  {31'b0, icache_req}, 32'd0);
    chk("mrst_vld",  {31'b0, inst_valid}, 32'd0);
    chk("mrst_inst", inst, 32'h0);
    chk("mrst_ipc",  inst_pc, 32'h0);
    nxt();
    rst  = 1'b0;
    base = del_pc.size();
    repeat (8) nxt();
    chk_log("mrst_first",  base, RESET_PC);
    chk_log("mrst_second", base + 1, RESET_PC + 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
